// File: rtl/memwb_writeback_pkg.sv
// Shared constants and types for the MEM/WB writeback block.
package memwb_writeback_pkg;

  localparam int N = 16;
  localparam logic [N-1:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]   HALT_OPC  = 5'b00000;

  typedef enum logic [1:0] {
    WRSEL_RT = 2'b00,
    WRSEL_RD = 2'b01,
    WRSEL_RS = 2'b10,
    WRSEL_R7 = 2'b11
  } wrsel_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_WAIT_MEM = 1'b1
  } state_e;

  typedef struct packed {
    logic         valid;
    logic [N-1:0] instr;
    logic [N-1:0] data;
    logic [1:0]   sel;
    logic         rwe;
  } memwb_t;

  function automatic logic is_halt(input logic [N-1:0] instr);
    return instr[N-1 -: 5] == HALT_OPC;
  endfunction

endpackage

// File: rtl/memwb_writeback_if.sv
// EX/MEM inputs, data-memory response and MEM/WB outputs of the writeback block.
interface memwb_writeback_if;
  import memwb_writeback_pkg::*;

  logic         exmem_valid;
  logic [N-1:0] exmem_instr;
  logic [N-1:0] exmem_alu;
  logic [N-1:0] exmem_pcplus2;
  logic         exmem_MemToReg;
  logic         exmem_SavePC;
  logic         exmem_MemRead;
  logic         exmem_RegWriteEnable;
  logic [1:0]   exmem_WriteRegSel;
  logic [N-1:0] mem_rdata;
  logic         mem_done;
  logic         mem_err;

  logic         stall_o;
  logic [N-1:0] writebackData;
  logic [N-1:0] Instruction_MEMWB_out;
  logic [1:0]   WriteRegSel_MEMWB_out;
  logic         RegWriteEnable_MEMWB_out;
  logic         memwb_valid;
  logic         halted;
  logic         err;

  modport master (
    output exmem_valid, exmem_instr, exmem_alu, exmem_pcplus2,
           exmem_MemToReg, exmem_SavePC, exmem_MemRead, exmem_RegWriteEnable,
           exmem_WriteRegSel, mem_rdata, mem_done, mem_err,
    input  stall_o, writebackData, Instruction_MEMWB_out, WriteRegSel_MEMWB_out,
           RegWriteEnable_MEMWB_out, memwb_valid, halted, err
  );

  modport slave (
    input  exmem_valid, exmem_instr, exmem_alu, exmem_pcplus2,
           exmem_MemToReg, exmem_SavePC, exmem_MemRead, exmem_RegWriteEnable,
           exmem_WriteRegSel, mem_rdata, mem_done, mem_err,
    output stall_o, writebackData, Instruction_MEMWB_out, WriteRegSel_MEMWB_out,
           RegWriteEnable_MEMWB_out, memwb_valid, halted, err
  );

endinterface

// File: rtl/memwb_writeback_wb_data_mux.sv
// Writeback value select: PC+2 over load data over ALU result.
module wb_data_mux
  import memwb_writeback_pkg::*;
(
  input  logic         save_pc_i,
  input  logic         mem_to_reg_i,
  input  logic [N-1:0] pcplus2_i,
  input  logic [N-1:0] load_i,
  input  logic [N-1:0] alu_i,
  output logic [N-1:0] data_o
);

  always_comb begin
    data_o = alu_i;
    if (save_pc_i) begin
      data_o = pcplus2_i;
    end else if (mem_to_reg_i) begin
      data_o = load_i;
    end
  end

endmodule

// File: rtl/memwb_writeback.sv
// MEM/WB pipeline register with multi-cycle load stall, writeback select,
// HALT retirement and sticky error reporting.
module memwb_writeback
  import memwb_writeback_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  memwb_writeback_if.slave   bus
);

  state_e       state_q, state_d;
  memwb_t       memwb_q, memwb_d;
  logic         halted_q, halted_d;
  logic         err_q, err_d;
  logic         load_pend;
  logic         capture;
  logic         mem_busy;
  logic         stall;
  logic [N-1:0] wb_data;

  wb_data_mux u_wb_data_mux (
    .save_pc_i    (bus.exmem_SavePC),
    .mem_to_reg_i (bus.exmem_MemToReg),
    .pcplus2_i    (bus.exmem_pcplus2),
    .load_i       (bus.mem_rdata),
    .alu_i        (bus.exmem_alu),
    .data_o       (wb_data)
  );

  always_comb begin
    load_pend = bus.exmem_valid & bus.exmem_MemRead & ~bus.mem_done;
    stall     = 1'b0;
    capture   = 1'b0;
    state_d   = state_q;

    if (halted_q) begin
      stall   = 1'b1;
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          stall   = load_pend;
          capture = bus.exmem_valid & ~load_pend;
          if (load_pend) state_d = ST_WAIT_MEM;
        end
        ST_WAIT_MEM: begin
          stall   = ~bus.mem_done;
          capture = bus.exmem_valid & bus.mem_done;
          if (bus.mem_done) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end

    memwb_d.valid = 1'b0;
    memwb_d.instr = NOP_INSTR;
    memwb_d.data  = '0;
    memwb_d.sel   = '0;
    memwb_d.rwe   = 1'b0;
    if (capture) begin
      memwb_d.valid = 1'b1;
      memwb_d.instr = bus.exmem_instr;
      memwb_d.data  = wb_data;
      memwb_d.sel   = bus.exmem_WriteRegSel;
      memwb_d.rwe   = bus.exmem_RegWriteEnable;
    end

    // A memory op counts as in flight while waiting, or while a read is presented.
    mem_busy = (state_q == ST_WAIT_MEM) |
               (~halted_q & bus.exmem_valid & bus.exmem_MemRead);
    halted_d = halted_q | (capture & is_halt(bus.exmem_instr));
    err_d    = err_q | (bus.mem_err & mem_busy) |
               (capture & bus.exmem_MemToReg & ~bus.exmem_MemRead);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      memwb_q.valid <= 1'b0;
      memwb_q.instr <= NOP_INSTR;
      memwb_q.data  <= '0;
      memwb_q.sel   <= '0;
      memwb_q.rwe   <= 1'b0;
      halted_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q  <= state_d;
      memwb_q  <= memwb_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign bus.stall_o                  = stall;
  assign bus.writebackData            = memwb_q.data;
  assign bus.Instruction_MEMWB_out    = memwb_q.instr;
  assign bus.WriteRegSel_MEMWB_out    = memwb_q.sel;
  assign bus.RegWriteEnable_MEMWB_out = memwb_q.rwe & memwb_q.valid;
  assign bus.memwb_valid              = memwb_q.valid;
  assign bus.halted                   = halted_q;
  assign bus.err                      = err_q;

endmodule

// File: tb/tb_memwb_writeback.sv
// Scoreboard bench for memwb_writeback: directed vectors, retirements checked by a monitor.
module tb_memwb_writeback;

  typedef struct {
    logic [15:0] data;
    logic [15:0] instr;
    logic [1:0]  sel;
    logic        rwe;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   bubble_cnt = 0;
  int   b0, b1;
  exp_t q[$];

  memwb_writeback_if bus ();

  memwb_writeback dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [15:0] ins, input logic [15:0] alu,
                        input logic [15:0] pc2, input logic m2r, input logic spc,
                        input logic mrd, input logic rwe, input logic [1:0] sel);
    bus.exmem_valid          = v;
    bus.exmem_instr          = ins;
    bus.exmem_alu            = alu;
    bus.exmem_pcplus2        = pc2;
    bus.exmem_MemToReg       = m2r;
    bus.exmem_SavePC         = spc;
    bus.exmem_MemRead        = mrd;
    bus.exmem_RegWriteEnable = rwe;
    bus.exmem_WriteRegSel    = sel;
  endtask

  task automatic idle();
    set_in(1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    bus.mem_done  = 1'b0;
    bus.mem_err   = 1'b0;
    bus.mem_rdata = 16'h0000;
  endtask

  task automatic push(input logic [15:0] d, input logic [15:0] ins, input logic [1:0] s,
                      input logic r);
    exp_t e;
    e.data = d; e.instr = ins; e.sel = s; e.rwe = r;
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk); #1;
  endtask

  // Monitor: every retirement is compared with the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.memwb_valid) begin
          if (q.size() == 0) begin
            check("unexpected_retire", 32'(bus.Instruction_MEMWB_out), 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            check("wb_data",  32'(bus.writebackData), 32'(e.data));
            check("wb_instr", 32'(bus.Instruction_MEMWB_out), 32'(e.instr));
            check("wb_sel",   32'(bus.WriteRegSel_MEMWB_out), 32'(e.sel));
            check("wb_rwe",   32'(bus.RegWriteEnable_MEMWB_out), 32'(e.rwe));
          end
        end else begin
          bubble_cnt++;
          check("bubble_rwe",   32'(bus.RegWriteEnable_MEMWB_out), 32'h0);
          check("bubble_instr", 32'(bus.Instruction_MEMWB_out), 32'h0800);
        end
      end
    end
  end

  initial begin
    idle();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    smp();
    check("rst_data",   32'(bus.writebackData), 32'h0);
    check("rst_instr",  32'(bus.Instruction_MEMWB_out), 32'h0800);
    check("rst_sel",    32'(bus.WriteRegSel_MEMWB_out), 32'h0);
    check("rst_rwe",    32'(bus.RegWriteEnable_MEMWB_out), 32'h0);
    check("rst_valid",  32'(bus.memwb_valid), 32'h0);
    check("rst_halted", 32'(bus.halted), 32'h0);
    check("rst_err",    32'(bus.err), 32'h0);
    check("rst_stall",  32'(bus.stall_o), 32'h0);
    cyc();

    // ADD -> ALU result
    set_in(1'b1, 16'hD8A4, 16'h1234, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    push(16'h1234, 16'hD8A4, 2'b01, 1'b1);
    smp(); check("add_stall", 32'(bus.stall_o), 32'h0);
    cyc();

    // 3-cycle load: two stall cycles, two bubbles
    set_in(1'b1, 16'h8A40, 16'h0010, 16'h0004, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
    push(16'hBEEF, 16'h8A40, 2'b00, 1'b1);
    smp(); check("ld_stall_1", 32'(bus.stall_o), 32'h1);
    b0 = bubble_cnt;
    cyc();
    smp(); check("ld_stall_2", 32'(bus.stall_o), 32'h1);
    cyc();
    bus.mem_done = 1'b1; bus.mem_rdata = 16'hBEEF;
    smp(); check("ld_stall_done", 32'(bus.stall_o), 32'h0);
    b1 = bubble_cnt;
    check("ld_bubbles", 32'(b1 - b0), 32'd2);
    cyc(); idle();

    // single-cycle load
    set_in(1'b1, 16'h8C60, 16'h0020, 16'h0006, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
    bus.mem_done = 1'b1; bus.mem_rdata = 16'hCAFE;
    push(16'hCAFE, 16'h8C60, 2'b00, 1'b1);
    smp(); check("ld1_stall", 32'(bus.stall_o), 32'h0);
    cyc(); idle();

    // spurious mem_done on a non-load is ignored
    set_in(1'b1, 16'hD9C8, 16'h5A5A, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    bus.mem_done = 1'b1; bus.mem_rdata = 16'hFFFF;
    push(16'h5A5A, 16'hD9C8, 2'b01, 1'b1);
    smp(); check("spur_stall", 32'(bus.stall_o), 32'h0);
    cyc(); idle();

    // valid instruction without register write
    set_in(1'b1, 16'h9000, 16'h0077, 16'h000A, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    push(16'h0077, 16'h9000, 2'b00, 1'b0);
    cyc();

    // JAL: SavePC wins over MemToReg
    set_in(1'b1, 16'h3000, 16'h1111, 16'h0042, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11);
    push(16'h0042, 16'h3000, 2'b11, 1'b1);
    cyc(); idle();
    cyc(); cyc();

    // reset during WAIT_MEM discards the read
    set_in(1'b1, 16'h8A40, 16'h0010, 16'h0004, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
    smp(); check("rstw_stall", 32'(bus.stall_o), 32'h1);
    cyc();
    #2 rst_n = 1'b0;
    #1 check("rstw_async_valid", 32'(bus.memwb_valid), 32'h0);
    idle();
    cyc(); cyc();
    rst_n = 1'b1;
    smp();
    check("rstw_err",   32'(bus.err), 32'h0);
    check("rstw_rwe",   32'(bus.RegWriteEnable_MEMWB_out), 32'h0);
    check("rstw_valid", 32'(bus.memwb_valid), 32'h0);
    cyc();
    set_in(1'b1, 16'hDA4C, 16'h0BAD, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    push(16'h0BAD, 16'hDA4C, 2'b01, 1'b1);
    smp(); check("rstw_fsm_run", 32'(bus.stall_o), 32'h0);
    cyc(); idle();

    // mem_err on a load sets sticky err
    set_in(1'b1, 16'h8E80, 16'h0030, 16'h000E, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
    bus.mem_done = 1'b1; bus.mem_rdata = 16'h1357; bus.mem_err = 1'b1;
    push(16'h1357, 16'h8E80, 2'b00, 1'b1);
    cyc(); idle();
    smp(); check("err_set", 32'(bus.err), 32'h1);
    cyc(); cyc();
    smp(); check("err_sticky", 32'(bus.err), 32'h1);
    cyc();

    // HALT retires, later ADDs are blocked
    set_in(1'b1, 16'h0000, 16'h0000, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
    push(16'h0000, 16'h0000, 2'b00, 1'b0);
    cyc();
    set_in(1'b1, 16'hD8A4, 16'h4444, 16'h0012, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
    smp();
    check("halt_set",   32'(bus.halted), 32'h1);
    check("halt_stall", 32'(bus.stall_o), 32'h1);
    cyc(); cyc();
    smp();
    check("halt_rwe",    32'(bus.RegWriteEnable_MEMWB_out), 32'h0);
    check("halt_valid",  32'(bus.memwb_valid), 32'h0);
    check("halt_stall2", 32'(bus.stall_o), 32'h1);
    idle();
    cyc();
    smp();
    check("sb_empty", 32'(q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memwb_writeback.md
# memwb_writeback

Writeback-end block of the 16-bit five-stage pipeline: registers the EX/MEM result into the MEM/WB pipeline register, stalls on a multi-cycle data-memory read, selects the writeback value (ALU result, load data, or PC+2), and drives the register-file write port inputs consumed by decode (`writebackData`, `Instruction_MEMWB_out`, `WriteRegSel_MEMWB_out`, `RegWriteEnable_MEMWB_out`). It also retires HALT and reports a sticky error.

## Interface
- `N`, 16, datapath width
- `NOP_INSTR`, 16'h0800, instruction word held after reset and in bubbles
- `HALT_OPC`, 5'b00000, opcode that sets `halted`

One clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  async active-low reset
- `exmem_valid`  in  1  EX/MEM holds a real instruction
- `exmem_instr`  in  N  instruction word
- `exmem_alu`  in  N  ALU result
- `exmem_pcplus2`  in  N  PC+2 of the instruction
- `exmem_MemToReg`, `exmem_SavePC`, `exmem_MemRead`, `exmem_RegWriteEnable`  in  1 each  control bits from decode
- `exmem_WriteRegSel`  in  2  00 rt[7:5], 01 rd[4:2], 10 rs[10:8], 11 R7
- `mem_rdata`  in  N  data-memory read data, valid with `mem_done`
- `mem_done`  in  1  data memory completed the outstanding read
- `mem_err`  in  1  data-memory error (unaligned/etc.)
- `stall_o`  out  1  hold IF/ID/EX/MEM stages this cycle
- `writebackData`  out  N  value to write
- `Instruction_MEMWB_out`  out  N  retiring instruction
- `WriteRegSel_MEMWB_out`  out  2  destination select code
- `RegWriteEnable_MEMWB_out`  out  1  RF write enable, qualified by valid
- `memwb_valid`  out  1  MEM/WB holds a real instruction
- `halted`  out  1  sticky, HALT retired
- `err`  out  1  sticky error

## Operation
- FSM states RUN, WAIT_MEM. Reset state RUN.
- RUN, `exmem_valid & exmem_MemRead & ~mem_done`: go WAIT_MEM; `stall_o`=1 combinationally this cycle; MEM/WB loads a bubble (valid 0, instr `NOP_INSTR`, RegWriteEnable 0).
- RUN otherwise: MEM/WB captures EX/MEM; if `exmem_valid`=0 a bubble is captured.
- WAIT_MEM: `stall_o`=1 while `~mem_done`, MEM/WB loads bubble; on `mem_done`, `stall_o`=0, capture EX/MEM (inputs held stable by the stall) with `mem_rdata`, return to RUN.
- `mem_done` with no pending read in RUN and `exmem_MemRead`=0: ignored.
- Writeback select, registered at capture: `SavePC` ? pcplus2 : `MemToReg` ? load data : alu. SavePC has priority over MemToReg.
- `RegWriteEnable_MEMWB_out` = captured RegWriteEnable & valid; bubbles never write.
- `halted` sets when a valid instruction with opcode [15:11]==`HALT_OPC` is captured; once set, all further captures are bubbles and `stall_o` is held 1.
- `err` sets on `mem_err` while a memory op is in flight or captured, or when captured `MemToReg` is 1 without `MemRead`; cleared only by reset.

## Timing
- Reset values: `writebackData` 0, `Instruction_MEMWB_out` `NOP_INSTR`, `WriteRegSel_MEMWB_out` 0, `RegWriteEnable_MEMWB_out` 0, `memwb_valid` 0, `halted` 0, `err` 0, `stall_o` 0, FSM RUN.
- Latency: EX/MEM value at edge k appears on MEM/WB outputs after edge k; register file writes at edge k+1 (bypassed to decode reads in that cycle).
- Single-cycle load (`mem_done` with request): no stall, 1-cycle latency.
- n-cycle load: `stall_o` high for n-1 cycles, exactly n-1 bubbles retire.
- Reset asserted mid-WAIT_MEM: immediate return to RUN, outstanding read discarded.
- `mem_done` and `halted` same cycle: the load retires, halt check follows its opcode.

## Structure
- Shared package: WriteRegSel codes, `NOP_INSTR`, `HALT_OPC`, FSM state encoding.
- One sub-module: `wb_data_mux` (3-input priority select); FSM and pipeline register inline.

## Test plan
- Reset release, no valid input -> outputs stay reset values, `Instruction_MEMWB_out`=16'h0800.
- ADD, alu=16'h1234, WriteRegSel 01, RWE 1 -> next cycle `writebackData`=16'h1234, RWE 1, sel 01.
- Load, `mem_done` low 2 cycles then high with rdata 16'hBEEF -> `stall_o` 1 for 2 cycles, 2 bubbles (RWE 0), then `writebackData`=16'hBEEF.
- JAL, pcplus2=16'h0042, SavePC 1, MemToReg 1 -> `writebackData`=16'h0042, sel 11.
- HALT captured, then valid ADDs -> `halted`=1, `stall_o`=1, subsequent RWE 0.
- `rst_n` low during WAIT_MEM, then release -> FSM RUN, no write, `err`=0; separate case `mem_err` on load -> `err`=1 sticky.
